// File: rtl/spi_arb_pkg.sv
// Shared types and length decoding for the SPI transfer arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_32 = 2'b10;

    // Code 2'b11 is treated as a 32-bit transfer.
    function automatic logic [5:0] len_to_bits(input logic [1:0] len);
        case (len)
            LEN_8:   return 6'd8;
            LEN_16:  return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side bus of the SPI transfer arbiter: requests in, grants/results out.
interface spi_xfer_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);

    logic [NUM_REQ-1:0]    IN_req;
    logic [2*NUM_REQ-1:0]  IN_len;
    logic [32*NUM_REQ-1:0] IN_wdata;
    logic [NUM_REQ-1:0]    OUT_ack;
    logic [NUM_REQ-1:0]    OUT_done;
    logic [31:0]           OUT_rdata;
    logic                  OUT_busy;

    modport master (
        output IN_req, IN_len, IN_wdata,
        input  OUT_ack, OUT_done, OUT_rdata, OUT_busy
    );

    modport slave (
        input  IN_req, IN_len, IN_wdata,
        output OUT_ack, OUT_done, OUT_rdata, OUT_busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request found scanning from ptr+1 upward.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(ptr_i) + i) % N;
            if (!valid_o && req_i[IW'(cand)]) begin
                valid_o              = 1'b1;
                grant_o[IW'(cand)]   = 1'b1;
                idx_o                = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one mode-0 SPI master between NUM_REQ requesters;
// MSB-first 8/16/32-bit transfers with a DIV-cycle half period.
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DIV     = 1
) (
    input  logic                clk,
    input  logic                rst,
    spi_xfer_arbiter_if.slave   bus,
    output logic                OUT_SPI_clk,
    output logic                OUT_SPI_mosi,
    input  logic                IN_SPI_miso,
    output logic                OUT_SPI_cs
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned DW = $clog2(DIV + 1);

    state_t               state_q;
    logic [DW-1:0]        div_q;
    logic [5:0]           bitcnt_q;
    logic [31:0]          tx_q;
    logic [31:0]          rx_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IW-1:0]        ptr_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [31:0]          rdata_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 cs_q;

    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        win_idx;
    logic                 win_valid;
    logic [31:0]          win_wdata;
    logic [1:0]           win_len;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i   (bus.IN_req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign win_wdata = bus.IN_wdata[32*win_idx +: 32];
    assign win_len   = bus.IN_len[2*win_idx +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bitcnt_q <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            gnt_q    <= '0;
            ptr_q    <= IW'(NUM_REQ - 1);
            ack_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        gnt_q    <= grant;
                        ptr_q    <= win_idx;
                        ack_q    <= grant;
                        tx_q     <= win_wdata;
                        mosi_q   <= win_wdata[31];
                        rx_q     <= '0;
                        bitcnt_q <= len_to_bits(win_len);
                        div_q    <= '0;
                        cs_q     <= 1'b0;
                        state_q  <= LOW;
                    end
                end
                LOW: begin
                    if (div_q == DW'(DIV - 1)) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[30:0], IN_SPI_miso};
                        state_q <= HIGH;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_q == DW'(DIV - 1)) begin
                        div_q    <= '0;
                        sclk_q   <= 1'b0;
                        bitcnt_q <= bitcnt_q - 1'b1;
                        if (bitcnt_q == 6'd1) begin
                            cs_q    <= 1'b1;
                            done_q  <= gnt_q;
                            rdata_q <= rx_q;
                            state_q <= IDLE;
                        end else begin
                            tx_q    <= {tx_q[30:0], 1'b0};
                            mosi_q  <= tx_q[30];
                            state_q <= LOW;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.OUT_ack   = ack_q;
    assign bus.OUT_done  = done_q;
    assign bus.OUT_rdata = rdata_q;
    assign bus.OUT_busy  = (state_q != IDLE);
    assign OUT_SPI_clk   = sclk_q;
    assign OUT_SPI_mosi  = mosi_q;
    assign OUT_SPI_cs    = cs_q;

endmodule
